// File: rtl/fpu_except_resolve.sv
// IEEE-754 single-precision special-case resolver: applies NaN/inf/zero/invalid/divzero
// overrides to the arithmetic-path result through a 2-stage valid/ready pipeline with sticky flags.
module fpu_except_resolve #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fpu_op,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic        opa_nan,
  input  logic        opb_nan,
  input  logic        opa_inf,
  input  logic        opb_inf,
  input  logic        opa_00,
  input  logic        opb_00,
  input  logic        snan,
  input  logic [31:0] nrm_result,
  input  logic        nrm_ovf,
  input  logic        nrm_unf,
  input  logic        nrm_inx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags,
  output logic        out_special,
  input  logic        flag_clear,
  output logic [4:0]  sticky_flags
);

  function automatic logic [31:0] inf_of(input logic s);
    return {s, 8'hFF, 23'h000000};
  endfunction

  function automatic logic [31:0] zero_of(input logic s);
    return {s, 31'h00000000};
  endfunction

  logic        s1_valid;
  logic [31:0] s1_result;
  logic [4:0]  s1_flags;
  logic        s1_special;
  logic        s2_load;
  logic        s1_load;
  logic        eb;
  logic        sx;
  logic [31:0] res;
  logic [4:0]  flags;
  logic        special;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = rst_n && s1_load;
  assign eb       = sign_b ^ (fpu_op == 2'd1);
  assign sx       = sign_a ^ sign_b;

  // Stage-1 resolve: first matching override wins, otherwise pass the arithmetic path through
  always_comb begin
    res     = nrm_result;
    flags   = {2'b00, nrm_ovf, nrm_unf, nrm_inx};
    special = 1'b0;
    if (opa_nan || opb_nan) begin
      res     = QNAN;
      flags   = {snan, 4'b0000};
      special = 1'b1;
    end else begin
      case (fpu_op)
        2'd0, 2'd1: begin
          if (opa_inf && opb_inf && (sign_a != eb)) begin
            res = QNAN; flags = 5'b10000; special = 1'b1;
          end else if (opa_inf) begin
            res = inf_of(sign_a); flags = 5'b00000; special = 1'b1;
          end else if (opb_inf) begin
            res = inf_of(eb); flags = 5'b00000; special = 1'b1;
          end else begin
            special = 1'b0;
          end
        end
        2'd2: begin
          if ((opa_inf && opb_00) || (opa_00 && opb_inf)) begin
            res = QNAN; flags = 5'b10000; special = 1'b1;
          end else if (opa_inf || opb_inf) begin
            res = inf_of(sx); flags = 5'b00000; special = 1'b1;
          end else if (opa_00 || opb_00) begin
            res = zero_of(sx); flags = 5'b00000; special = 1'b1;
          end else begin
            special = 1'b0;
          end
        end
        2'd3: begin
          if ((opa_00 && opb_00) || (opa_inf && opb_inf)) begin
            res = QNAN; flags = 5'b10000; special = 1'b1;
          end else if (opa_inf) begin
            res = inf_of(sx); flags = 5'b00000; special = 1'b1;
          end else if (opb_00) begin
            res = inf_of(sx); flags = 5'b01000; special = 1'b1;
          end else if (opb_inf || opa_00) begin
            res = zero_of(sx); flags = 5'b00000; special = 1'b1;
          end else begin
            special = 1'b0;
          end
        end
        default: begin
          special = 1'b0;
        end
      endcase
    end
  end

  // Stage-1 register: holds the resolved beat until stage 2 can take it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_result  <= 32'h00000000;
      s1_flags   <= 5'b00000;
      s1_special <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_result  <= res;
        s1_flags   <= flags;
        s1_special <= special;
      end
    end
  end

  // Stage-2 output register: contents frozen while the beat waits for out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= 32'h00000000;
      out_flags   <= 5'b00000;
      out_special <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= s1_result;
        out_flags   <= s1_flags;
        out_special <= s1_special;
      end
    end
  end

  // Sticky flags: a same-cycle transfer survives a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= 5'b00000;
    end else begin
      sticky_flags <= (flag_clear ? 5'b00000 : sticky_flags) |
                      ((out_valid && out_ready) ? out_flags : 5'b00000);
    end
  end

endmodule

// File: tb/tb_fpu_except_resolve.sv
// Directed testbench for fpu_except_resolve: special-case overrides, pipeline backpressure and sticky flags.
module tb_fpu_except_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fpu_op = 2'd0;
  logic        sign_a = 1'b0, sign_b = 1'b0;
  logic        opa_nan = 1'b0, opb_nan = 1'b0, opa_inf = 1'b0, opb_inf = 1'b0;
  logic        opa_00 = 1'b0, opb_00 = 1'b0, snan = 1'b0;
  logic [31:0] nrm_result = 32'h0;
  logic        nrm_ovf = 1'b0, nrm_unf = 1'b0, nrm_inx = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic        out_special;
  logic        flag_clear = 1'b0;
  logic [4:0]  sticky_flags;

  int checks = 0;
  int errors = 0;

  fpu_except_resolve dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fpu_op(fpu_op), .sign_a(sign_a), .sign_b(sign_b),
    .opa_nan(opa_nan), .opb_nan(opb_nan), .opa_inf(opa_inf), .opb_inf(opb_inf),
    .opa_00(opa_00), .opb_00(opb_00), .snan(snan),
    .nrm_result(nrm_result), .nrm_ovf(nrm_ovf), .nrm_unf(nrm_unf), .nrm_inx(nrm_inx),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_special(out_special),
    .flag_clear(flag_clear), .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // cls = {opa_nan, opb_nan, opa_inf, opb_inf, opa_00, opb_00, snan}; nf = {ovf, unf, inx}
  task automatic set_in(input logic [1:0] op, input logic sa, input logic sb,
                        input logic [6:0] cls, input logic [31:0] nr, input logic [2:0] nf);
    fpu_op = op; sign_a = sa; sign_b = sb;
    {opa_nan, opb_nan, opa_inf, opb_inf, opa_00, opb_00, snan} = cls;
    nrm_result = nr;
    {nrm_ovf, nrm_unf, nrm_inx} = nf;
  endtask

  // One beat through an empty pipeline with out_ready high; called at a negedge
  task automatic run_beat(input string tag, input logic [1:0] op, input logic sa, input logic sb,
                          input logic [6:0] cls, input logic [31:0] nr, input logic [2:0] nf,
                          input logic clr, input logic [31:0] er, input logic [4:0] ef,
                          input logic es, input logic [4:0] estk);
    set_in(op, sa, sb, cls, nr, nf);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat"}, 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, out_result, er);
    chk({tag, "_flags"}, 32'(out_flags), 32'(ef));
    chk({tag, "_special"}, 32'(out_special), 32'(es));
    flag_clear = clr;
    @(posedge clk); @(negedge clk);
    flag_clear = 1'b0;
    chk({tag, "_sticky"}, 32'(sticky_flags), 32'(estk));
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    run_beat("div_by_zero", 2'd3, 1'b0, 1'b1, 7'b0000010, 32'h40A0_0000, 3'b000, 1'b0,
             32'hFF80_0000, 5'b01000, 1'b1, 5'b01000);
    run_beat("sub_inf_inf", 2'd1, 1'b0, 1'b0, 7'b0011000, 32'h0, 3'b000, 1'b0,
             32'h7FC0_0000, 5'b10000, 1'b1, 5'b11000);
    run_beat("add_inf_inf", 2'd0, 1'b0, 1'b0, 7'b0011000, 32'h0, 3'b000, 1'b0,
             32'h7F80_0000, 5'b00000, 1'b1, 5'b11000);
    run_beat("mul_snan", 2'd2, 1'b0, 1'b0, 7'b1000001, 32'h0, 3'b000, 1'b0,
             32'h7FC0_0000, 5'b10000, 1'b1, 5'b11000);
    run_beat("mul_qnan", 2'd2, 1'b0, 1'b0, 7'b1000000, 32'h0, 3'b111, 1'b0,
             32'h7FC0_0000, 5'b00000, 1'b1, 5'b11000);
    run_beat("mul_inf_zero", 2'd2, 1'b1, 1'b0, 7'b0010010, 32'h0, 3'b000, 1'b0,
             32'h7FC0_0000, 5'b10000, 1'b1, 5'b11000);
    run_beat("mul_zero", 2'd2, 1'b1, 1'b0, 7'b0000100, 32'h1234_5678, 3'b001, 1'b0,
             32'h8000_0000, 5'b00000, 1'b1, 5'b11000);
    run_beat("div_zero_zero", 2'd3, 1'b0, 1'b0, 7'b0000110, 32'h0, 3'b000, 1'b0,
             32'h7FC0_0000, 5'b10000, 1'b1, 5'b11000);
    run_beat("div_by_inf", 2'd3, 1'b0, 1'b1, 7'b0001000, 32'h0, 3'b000, 1'b0,
             32'h8000_0000, 5'b00000, 1'b1, 5'b11000);
    run_beat("sub_inf_b", 2'd1, 1'b0, 1'b0, 7'b0001000, 32'h0, 3'b000, 1'b0,
             32'hFF80_0000, 5'b00000, 1'b1, 5'b11000);
    run_beat("add_zero_normal", 2'd0, 1'b0, 1'b0, 7'b0000100, 32'h4040_0000, 3'b000, 1'b0,
             32'h4040_0000, 5'b00000, 1'b0, 5'b11000);
    run_beat("normal_inx", 2'd2, 1'b0, 1'b0, 7'b0000000, 32'h3F80_0000, 3'b001, 1'b0,
             32'h3F80_0000, 5'b00001, 1'b0, 5'b11001);
    run_beat("normal_ovf", 2'd0, 1'b0, 1'b0, 7'b0000000, 32'h7F7F_FFFF, 3'b101, 1'b0,
             32'h7F7F_FFFF, 5'b00101, 1'b0, 5'b11101);

    flag_clear = 1'b1;
    @(posedge clk); @(negedge clk);
    flag_clear = 1'b0;
    chk("clear_no_xfer", 32'(sticky_flags), 32'd0);

    run_beat("unf_before_clr", 2'd0, 1'b0, 1'b0, 7'b0000000, 32'h0080_0000, 3'b010, 1'b0,
             32'h0080_0000, 5'b00010, 1'b0, 5'b00010);
    run_beat("clr_with_divzero", 2'd3, 1'b1, 1'b0, 7'b0000010, 32'h0, 3'b000, 1'b1,
             32'hFF80_0000, 5'b01000, 1'b1, 5'b01000);

    // Backpressure: four normal beats, out_ready low until the pipe fills
    out_ready = 1'b0;
    set_in(2'd0, 1'b0, 1'b0, 7'b0, 32'hA000_0001, 3'b000);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_ready_after1", 32'(in_ready), 32'd1);
    set_in(2'd0, 1'b0, 1'b0, 7'b0, 32'hA000_0002, 3'b000);
    @(posedge clk); @(negedge clk);
    chk("bp_full", 32'(in_ready), 32'd0);
    chk("bp_head", out_result, 32'hA000_0001);
    set_in(2'd0, 1'b0, 1'b0, 7'b0, 32'hA000_0003, 3'b000);
    @(posedge clk); @(negedge clk);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_result", out_result, 32'hA000_0001);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("bp_out2", out_result, 32'hA000_0002);
    set_in(2'd0, 1'b0, 1'b0, 7'b0, 32'hA000_0004, 3'b000);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out3", out_result, 32'hA000_0003);
    chk("bp_out3_valid", 32'(out_valid), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("bp_out4", out_result, 32'hA000_0004);
    chk("bp_out4_valid", 32'(out_valid), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_sticky", 32'(sticky_flags), 32'(5'b01000));

    // Mid-stream asynchronous reset discards in-flight beats
    out_ready = 1'b0;
    set_in(2'd3, 1'b0, 1'b0, 7'b0000110, 32'h0, 3'b000);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd0);
    chk("async_rst_sticky", 32'(sticky_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_discard", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
